seq_det_sched: RTL
==================

# seq_det_sched

Round-robin scheduler that time-shares one Mealy "101" detector core among NCH serial bit channels. Each channel offers one bit per handshake. The scheduler grants at most one channel per cycle and swaps that channel's saved detector state in and out of a per-channel state table. It reports detections with the originating channel and sits between the serial front-ends and the event/interrupt logic.

## Interface
- NCH, 4, number of serial channels (2..16)
- CHW, $clog2(NCH), channel index width
- CNT_W, 8, per-channel hit counter width (used only with SEQ_DET_HIT_CNT_EN)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  scheduler enable; when low, no grants are issued
- bit_valid  input  NCH  channel i offers bit_data[i]
- bit_data  input  NCH  serial bit per channel
- bit_ready  output  NCH  one-hot grant; a bit transfers when bit_valid[i] & bit_ready[i]
- ch_clr  input  NCH  synchronous per-channel state clear
- det_valid  output  1  one-cycle pulse: "101" completed on det_ch
- det_ch  output  CHW  channel of the detection
- cnt_sel  input  CHW  counter read select
- cnt_clr  input  1  clears the counter at cnt_sel
- cnt_out  output  CNT_W  hit count of the cnt_sel channel (combinational read)

## Operation
- State table st[NCH], 2 bits each: S0 (idle), S1 (seen 1), S2 (seen 10). Encoding S0=0, S1=1, S2=2.
- Core transition function:
  - S0: x=1 → S1, x=0 → S0
  - S1: x=1 → S1, x=0 → S2
  - S2: x=1 → S1 with hit, x=0 → S0
  - Code 3 → S0, no hit
- Detection overlaps: stream 10101 produces two hits.
- Arbitration:
  - Eligible channels: bit_valid[i] & !ch_clr[i] & en.
  - The first eligible channel at or after rr_ptr (wrapping) is granted.
  - bit_ready is combinational from the eligible set and rr_ptr. At most one bit is set.
  - On a transfer, st[g] is updated and rr_ptr becomes (g+1) mod NCH. With no transfer, rr_ptr holds.
- ch_clr[i] sets st[i]=S0 at the next edge and blocks the grant to channel i that cycle. Other channels are still arbitrated.
- Ungranted channels keep their state indefinitely. Gaps in bit_valid do not reset detection.
- en low: bit_ready=0, state and rr_ptr hold. ch_clr and cnt_clr still act.

## Timing
- Grant is zero-cycle: bit_ready is valid in the same cycle as bit_valid.
- Detection latency is 1 cycle. det_valid/det_ch are registered and asserted in the cycle after the transfer of the completing "1".
- Peak throughput: 1 bit/cycle aggregate. With all channels valid, each channel gets 1 bit per NCH cycles.
- Reset (rst low, asynchronous):
  - all st=S0, rr_ptr=0
  - det_valid=0, det_ch=0
  - counters=0
  - bit_ready forced to 0 while rst is low
- Reset mid-stream discards partial patterns on every channel.
- det_ch holds its last value when det_valid=0.

## Configuration
- SEQ_DET_HIT_CNT_EN defined:
  - Per-channel saturating counters of CNT_W bits increment in the same cycle det_valid is asserted. They stick at 2^CNT_W-1.
  - cnt_clr zeroes cnt[cnt_sel] at the next edge. A clear coinciding with an increment on the same channel leaves 0.
- SEQ_DET_HIT_CNT_EN undefined: no counters are built, cnt_out is tied to 0, and cnt_sel/cnt_clr are ignored.

## Structure
- Shared package seq_det_pkg holds:
  - the state typedef (S0/S1/S2, 2-bit)
  - the state constants
  - a next-state/hit function reused by the single-channel detectors
- One sub-module, seq_det_core: purely combinational (state, x) → (next state, hit). It is instantiated once and fed the granted channel's state.
- The arbiter, state table, output register and counters live in seq_det_sched.

## Test plan
- Single channel 0, bits 1,0,1 on consecutive cycles → bit_ready[0]=1 each cycle; det_valid=1, det_ch=0 one cycle after the third transfer.
- Channel 2 streams 1,0,1,0,1 → exactly two det_valid pulses for det_ch=2 (overlap); cnt_out with cnt_sel=2 reads 2 when the macro is defined.
- All 4 channels continuously valid → grants rotate 0,1,2,3,0...; each channel's interleaved 101 is detected exactly once, with no cross-channel corruption.
- Channel 1 at S2, ch_clr[1] asserted with bit_valid[1]=1,x=1 → bit_ready[1]=0, no detection; following bits 1,0,1 detected normally.
- rst pulsed low while channel 3 is in S2, then x=1 → no detection; det_valid=0 and bit_ready=0 during reset.
- With the macro defined, CNT_W=2, five hits on channel 0 → cnt_out=3 (saturated); cnt_clr coinciding with a hit → cnt_out=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared "101" detector types and the per-bit step function.
// Latency: none (types and a pure function). Backpressure: n/a.
// Used by the single-channel detector core and the scheduler.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_st_t;

    localparam det_st_t ST_IDLE = S0;

    typedef struct packed {
        det_st_t nxt;
        logic    hit;
    } det_step_t;

    // Code 3 is unreachable in normal operation; it falls back to idle without a hit.
    function automatic det_step_t det_step(input logic [1:0] st, input logic x);
        det_step_t r;
        r.nxt = ST_IDLE;
        r.hit = 1'b0;
        case (st)
            2'd0: r.nxt = x ? S1 : S0;
            2'd1: r.nxt = x ? S1 : S2;
            2'd2: begin
                r.nxt = x ? S1 : S0;
                r.hit = x;
            end
            default: r.nxt = ST_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Serial-channel handshake and detection report bundle.
// Latency: n/a (wires only). Backpressure: bit_ready is the one-hot grant.
// master = front-ends/event logic side, slave = scheduler side.
interface seq_det_sched_if #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
);
    logic [NCH-1:0] bit_valid;
    logic [NCH-1:0] bit_data;
    logic [NCH-1:0] bit_ready;
    logic [NCH-1:0] ch_clr;
    logic           det_valid;
    logic [CHW-1:0] det_ch;

    modport master (
        output bit_valid, bit_data, ch_clr,
        input  bit_ready, det_valid, det_ch
    );

    modport slave (
        input  bit_valid, bit_data, ch_clr,
        output bit_ready, det_valid, det_ch
    );
endinterface

// File: rtl/seq_det_core.sv
// Combinational Mealy "101" step: (state, bit) -> (next state, hit).
// Latency: 0 cycles. Backpressure: none, evaluated every cycle.
module seq_det_core
    import seq_det_pkg::*;
(
    input  det_st_t st,
    input  logic    x,
    output det_st_t nxt,
    output logic    hit
);

    det_step_t step;

    assign step = det_step(st, x);
    assign nxt  = step.nxt;
    assign hit  = step.hit;

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one "101" detector across NCH channels; SEQ_DET_HIT_CNT_EN adds hit counters.
// Latency: grant 0 cycles, det_valid/det_ch 1 cycle after the completing transfer.
// Backpressure: at most one channel granted per cycle; ungranted channels hold their bit.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CHW   = $clog2(NCH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    seq_det_sched_if.slave   bus,
    input  logic [CHW-1:0]   cnt_sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_out
);

    det_st_t        st_q [NCH];
    logic [CHW-1:0] rr_ptr;
    logic           det_valid_q;
    logic [CHW-1:0] det_ch_q;

    logic [NCH-1:0] elig;
    logic           gnt_vld;
    logic [CHW-1:0] gnt_idx;
    logic [CHW-1:0] nxt_ptr;
    det_st_t        core_nxt;
    logic           core_hit;

    // Reset also gates eligibility so bit_ready stays low while rst is asserted.
    assign elig = bus.bit_valid & ~bus.ch_clr & {NCH{en & rst}};

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CHW'(idx);
            end
        end
    end

    assign bus.bit_ready = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
    assign nxt_ptr       = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

    seq_det_core u_core (
        .st  (st_q[gnt_idx]),
        .x   (bus.bit_data[gnt_idx]),
        .nxt (core_nxt),
        .hit (core_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) st_q[i] <= ST_IDLE;
            rr_ptr      <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            det_valid_q <= gnt_vld & core_hit;
            if (gnt_vld) begin
                st_q[gnt_idx] <= core_nxt;
                rr_ptr        <= nxt_ptr;
                if (core_hit) det_ch_q <= gnt_idx;
            end
            // A cleared channel is never granted, so this cannot collide with the update above.
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) st_q[i] <= ST_IDLE;
            end
        end
    end

    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;

`ifdef SEQ_DET_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cnt_clr && cnt_sel == CHW'(i)) begin
                    cnt_q[i] <= '0;
                end else if (gnt_vld && core_hit && gnt_idx == CHW'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_out = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_sel, cnt_clr};
    assign cnt_out    = '0;
`endif

endmodule
